// File: rtl/mux_serial_port.sv
// Memory-mapped 8N1 serial port: STATUS/DATA register pair, 4-entry TX FIFO,
// and a single-byte receive buffer with overrun detection.
module mux_serial_port #(
  parameter int unsigned DIVISOR = 520,
  parameter logic [15:0] BASE    = 16'hF200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [18:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        selected,
  input  logic        rxd,
  output logic        txd
);

  localparam logic [15:0] BaseData = BASE + 16'd1;
  localparam logic [15:0] BitLast  = 16'(DIVISOR - 1);
  localparam logic [15:0] HalfLast = 16'((DIVISOR / 2) - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic sel_status, sel_data, wr_status, wr_data;
  logic unused_addr_hi;

  assign sel_status     = (address[15:0] == BASE);
  assign sel_data       = (address[15:0] == BaseData);
  assign selected       = sel_status | sel_data;
  assign wr_status      = write_en & sel_status;
  assign wr_data        = write_en & sel_data;
  assign unused_addr_hi = ^address[18:16];

  // TX FIFO
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       fifo_full, fifo_empty, push, tx_pop;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign push       = wr_data & ~fifo_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = wr_ptr_q + 2'd1;
    if (tx_pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !tx_pop)      count_d = count_q + 3'd1;
    else if (!push && tx_pop) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= data_in;
  end

  // TX FSM
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TxStart;
          tx_shift_d = fifo_q[rd_ptr_q];
          txd_d      = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
          txd_d      = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_bit_d   = '0;
            tx_state_d = TxStop;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_state_d = TxStart;
            tx_shift_d = fifo_q[rd_ptr_q];
            txd_d      = 1'b0;
          end else begin
            tx_state_d = TxIdle;
            txd_d      = 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign txd = txd_q;

  // RX path
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        // Needs a high-then-low sequence, so a line stuck low never rearms.
        if (rx_prev_q && !rx_s2_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_bit_d   = '0;
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          rx_done    = rx_s2_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Status flags and receive buffer
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_full_q, rx_full_d, rx_overrun_q, rx_overrun_d;
  logic       tx_overflow_q, tx_overflow_d;

  always_comb begin
    rx_data_d     = rx_data_q;
    rx_full_d     = rx_full_q;
    rx_overrun_d  = rx_overrun_q;
    tx_overflow_d = tx_overflow_q;
    if (wr_status) begin
      rx_full_d     = 1'b0;
      rx_overrun_d  = 1'b0;
      tx_overflow_d = 1'b0;
    end
    if (wr_data && fifo_full) tx_overflow_d = 1'b1;
    // Evaluated after the clear so a same-edge STATUS write frees the buffer.
    if (rx_done) begin
      if (rx_full_d) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d = rx_shift_q;
        rx_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (sel_status) begin
      data_out = {4'b0000, tx_overflow_q, rx_overrun_q, ~fifo_full, rx_full_q};
    end else if (sel_data) begin
      data_out = rx_data_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tx_state_q    <= TxIdle;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      txd_q         <= 1'b1;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RxIdle;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_full_q     <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      txd_q         <= txd_d;
      rx_s1_q       <= rxd;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_full_q     <= rx_full_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

endmodule

// File: tb/tb_mux_serial_port.sv
// Scoreboard bench for mux_serial_port: frame-level TX/RX reference model,
// queued expectations popped by independent TX-line and register-read monitors.
module tb_mux_serial_port;

  localparam int          DIV  = 8;
  localparam logic [15:0] BASE = 16'hF200;
  localparam logic [18:0] A_ST = {3'b000, BASE};
  localparam logic [18:0] A_DT = {3'b000, BASE + 16'd1};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [18:0] address = '0;
  logic        write_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        selected;
  logic        rxd = 1'b1;
  logic        txd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mux_serial_port #(.DIVISOR(DIV), .BASE(BASE)) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(data_out),
    .selected(selected),
    .rxd     (rxd),
    .txd     (txd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: each popped byte occupies the line for 10*DIV clocks.
  int         m_count = 0;
  int         m_busy = 0;
  bit         m_ovf = 0, m_rx_full = 0, m_rx_over = 0;
  logic [7:0] m_rx_data = 8'h00;
  logic [7:0] tx_exp[$];
  int         tx_starts[$];
  bit         m_free;
  int         m_pre;

  always @(posedge clock) begin
    if (!reset) begin
      m_count = 0; m_busy = 0; m_ovf = 0;
      m_rx_full = 0; m_rx_over = 0; m_rx_data = 8'h00;
      tx_exp.delete();
    end else begin
      m_free = (m_busy == 0);
      m_pre  = m_count;
      if (!m_free) m_busy--;
      if (write_en && address[15:0] == BASE) begin
        m_ovf = 0; m_rx_full = 0; m_rx_over = 0;
      end
      if (write_en && address[15:0] == BASE + 16'd1) begin
        if (m_pre < 4) begin
          m_count++;
          tx_exp.push_back(data_in);
        end else begin
          m_ovf = 1;
        end
      end
      if (m_free && m_pre > 0) begin
        m_count--;
        m_busy = 10 * DIV - 1;
      end
    end
  end

  function automatic logic [8:0] exp_status();
    return {1'b1, 4'b0000, m_ovf, m_rx_over, (m_count < 4), m_rx_full};
  endfunction

  // TX line monitor: decodes each frame and requires every bit to hold DIV clocks.
  initial begin : tx_mon
    logic [9:0] bits;
    logic [7:0] e;
    bit bad, aborted;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && txd === 1'b0) begin
        tx_starts.push_back(cyc);
        bad = 0; aborted = 0; bits = '0;
        for (int i = 0; i < 10 * DIV; i++) begin
          if (i > 0) @(negedge clock);
          if (reset !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (i % DIV == 0) bits[i / DIV] = txd;
          else if (txd !== bits[i / DIV]) bad = 1;
        end
        if (!aborted) begin
          if (tx_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_frame: got unexpected byte %0h, expected none", bits[8:1]);
          end else begin
            e = tx_exp.pop_front();
            check("tx_frame", {21'd0, bad, bits}, {21'd0, 1'b0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  // Register-read monitor
  logic [8:0] rd_exp_q[$];
  string      rd_name_q[$];
  bit         rd_pend = 0;
  logic [8:0] rexp;
  string      rname;

  always @(negedge clock) begin
    if (rd_pend && rd_exp_q.size() > 0) begin
      rexp  = rd_exp_q.pop_front();
      rname = rd_name_q.pop_front();
      check({rname, "_sel"}, {31'd0, selected}, {31'd0, rexp[8]});
      check(rname, {24'd0, data_out}, {24'd0, rexp[7:0]});
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(logic [18:0] a, logic [7:0] d);
    address = a; data_in = d; write_en = 1'b1;
    @(posedge clock); #1;
    write_en = 1'b0;
  endtask

  task automatic rd(string name, logic [18:0] a, logic [8:0] exp);
    address = a;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_pend = 1;
    @(posedge clock); #1;
    rd_pend = 0;
  endtask

  task automatic send_rx(logic [7:0] b, bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      idle(DIV);
    end
    rxd = 1'b1;
    idle(4);
    if (stop) begin
      if (m_rx_full) m_rx_over = 1;
      else begin
        m_rx_data = b;
        m_rx_full = 1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || m_busy != 0 || m_count != 0) && n < 3000) begin
      idle(1);
      n++;
    end
    check("tx_drain", tx_exp.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] b;
    repeat (3) @(posedge clock);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    reset = 1'b1;
    idle(2);
    rd("rst_status", A_ST, 9'h102);
    rd("rst_data", A_DT, 9'h100);

    // Single byte: start bit appears one edge after the write.
    wr(A_DT, 8'hA5);
    @(negedge clock);
    check("tx_lat_pre", {31'd0, txd}, 32'd1);
    @(negedge clock);
    check("tx_lat", {31'd0, txd}, 32'd0);
    @(posedge clock); #1;
    idle(90);
    check("tx_a5_done", tx_exp.size(), 0);

    // FIFO fill, overflow and back-to-back frames.
    tx_starts.delete();
    for (int i = 1; i <= 6; i++) wr(A_DT, 8'(i));
    rd("st_full", A_ST, 9'h108);
    idle(80);
    rd("st_ready_again", A_ST, 9'h10A);
    drain();
    check("tx_nframes", tx_starts.size(), 5);
    for (int i = 1; i < 5 && i < tx_starts.size(); i++)
      check("tx_gap", tx_starts[i] - tx_starts[i-1], 10 * DIV);
    wr(A_ST, 8'h00);
    rd("st_clr_ovf", A_ST, 9'h102);

    // Receive, overrun, simultaneous clear+load, clear.
    send_rx(8'h3C, 1);
    rd("st_rx1", A_ST, 9'h103);
    rd("dt_rx1", A_DT, 9'h13C);
    send_rx(8'h77, 1);
    rd("st_ovr", A_ST, 9'h107);
    rd("dt_ovr", A_DT, 9'h13C);
    fork
      send_rx(8'h96, 1);
      begin
        idle(10 * DIV - 2);
        wr(A_ST, 8'h5A);
      end
    join
    rd("st_simul", A_ST, 9'h103);
    rd("dt_simul", A_DT, 9'h196);
    wr(A_ST, 8'hFF);
    rd("st_clr", A_ST, 9'h102);

    // Glitch and framing error, then a good frame to show RX rearmed.
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(20);
    rd("st_glitch", A_ST, 9'h102);
    send_rx(8'h55, 0);
    rd("st_frame_err", A_ST, 9'h102);
    b = 8'($urandom);
    send_rx(b, 1);
    rd("st_rearm", A_ST, 9'h103);
    rd("dt_rearm", A_DT, {1'b1, b});
    wr(A_ST, 8'h00);

    // Address decode
    rd("st_alias", 19'h7F200, 9'h102);
    rd("unsel", 19'h0F202, 9'h000);

    // Randomized RX bytes with random clears
    for (int i = 0; i < 6; i++) begin
      send_rx(8'($urandom), 1);
      rd("rnd_rx_st", A_ST, exp_status());
      rd("rnd_rx_dt", A_DT, {1'b1, m_rx_data});
      if ($urandom_range(0, 1) == 1) wr(A_ST, 8'($urandom));
    end

    // Randomized TX writes with random gaps
    for (int i = 0; i < 10; i++) begin
      wr(A_DT, 8'($urandom));
      rd("rnd_tx_st", A_ST, exp_status());
      idle($urandom_range(1, 60));
    end
    drain();
    rd("rnd_tx_end", A_ST, exp_status());
    wr(A_ST, 8'h00);

    // Reset during a TX data bit
    wr(A_DT, 8'h5A);
    idle(3 * DIV + 3);
    #1 reset = 1'b0;
    #1 check("rst_mid_txd", {31'd0, txd}, 32'd1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    idle(2);
    rd("st_after_rst", A_ST, 9'h102);
    rd("dt_after_rst", A_DT, 9'h100);
    idle(12 * DIV);
    check("rst_no_frame", {31'd0, txd}, 32'd1);

    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
